// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared types and constants for the MAC dot-product sequencer
package mac_seq_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;
    localparam int LANES  = 8;
    localparam int LANE_W = 8;
    localparam int PSUM_W = 16;
    typedef logic [LANES-1:0][LANE_W-1:0] lanes_t;
    function automatic lanes_t unpack_lanes(input logic [LANES*LANE_W-1:0] d);
        lanes_t l;
        for (int i = 0; i < LANES; i++) l[i] = d[i*LANE_W +: LANE_W];
        return l;
    endfunction
endpackage

// File: rtl/mac_seq_addr_gen.sv
// mac_seq_addr_gen: beat, weight-pointer and output-neuron counters for the sequencer
//  clk, rst_n          clock, asynchronous active-low reset
//  start               zero all counters (command accepted)
//  issue               one beat read issued this cycle
//  next_out            result handed off, advance to next neuron
//  n_beats, n_out      latched command sizes
//  beat, wgt_ptr       activation beat address / running weight beat address
//  out_idx             current output-neuron index
//  issue_last, out_last  last beat of this neuron / last neuron of this command
module mac_seq_addr_gen
    import mac_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        issue,
    input  logic        next_out,
    input  logic [7:0]  n_beats,
    input  logic [7:0]  n_out,
    output logic [7:0]  beat,
    output logic [15:0] wgt_ptr,
    output logic [7:0]  out_idx,
    output logic        issue_last,
    output logic        out_last
);
    assign issue_last = beat == n_beats - 8'd1;
    assign out_last   = out_idx == n_out - 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat    <= '0;
            wgt_ptr <= '0;
            out_idx <= '0;
        end else if (start) begin
            beat    <= '0;
            wgt_ptr <= '0;
            out_idx <= '0;
        end else begin
            if (issue) begin
                beat    <= issue_last ? '0 : beat + 8'd1;
                wgt_ptr <= wgt_ptr + 16'd1;
            end
            if (next_out) out_idx <= out_idx + 8'd1;
        end
    end
endmodule

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: command-driven feeder for the 8-way INT8 MAC array, accumulating one dot product per neuron
//  clk, rst_n                       clock, asynchronous active-low reset
//  cmd_valid/cmd_ready/cmd_n_out/cmd_n_beats   command port (accepted only in IDLE)
//  act_rd_en/act_rd_addr/act_rd_data  activation buffer, 1-cycle read latency
//  wgt_rd_en/wgt_rd_addr/wgt_rd_data  weight buffer, 1-cycle read latency
//  arr_enable/arr_clear_acc/arr_data/arr_weight  MAC array drive
//  arr_partial_sum/arr_valid        MAC array returns
//  res_valid/res_ready/res_data/res_idx  result port
//  done                             one-cycle pulse on command completion
//  err_unexp                        sticky: array return outside ISSUE/DRAIN
//  Build option MAC_SEQ_RELU_EN: clamp negative results to zero on the result port.
module mac_dot_sequencer
    import mac_seq_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int BEAT_AW = 8,
    parameter int ARR_LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_n_out,
    input  logic [7:0]               cmd_n_beats,
    output logic                     act_rd_en,
    output logic [BEAT_AW-1:0]       act_rd_addr,
    input  logic [63:0]              act_rd_data,
    output logic                     wgt_rd_en,
    output logic [15:0]              wgt_rd_addr,
    input  logic [63:0]              wgt_rd_data,
    output logic                     arr_enable,
    output logic                     arr_clear_acc,
    output logic [7:0][7:0]          arr_data,
    output logic [7:0][7:0]          arr_weight,
    input  logic signed [PSUM_W-1:0] arr_partial_sum,
    input  logic                     arr_valid,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [ACC_W-1:0]  res_data,
    output logic [7:0]               res_idx,
    output logic                     done,
    output logic                     err_unexp
);
    state_t                   state;
    logic [7:0]               n_out_q, n_beats_q, ret_cnt, beat;
    logic signed [ACC_W-1:0]  acc;
    logic                     issue_last, out_last, accept;

    assign accept     = cmd_valid && cmd_ready;
    assign wgt_rd_en  = act_rd_en;
    assign act_rd_addr = BEAT_AW'(beat);
    assign arr_data   = unpack_lanes(act_rd_data);
    assign arr_weight = unpack_lanes(wgt_rd_data);
`ifdef MAC_SEQ_RELU_EN
    assign res_data = acc[ACC_W-1] ? '0 : acc;
`else
    assign res_data = acc;
`endif

    mac_seq_addr_gen u_addr (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (accept),
        .issue      (act_rd_en),
        .next_out   (state == OUTPUT && res_ready),
        .n_beats    (n_beats_q),
        .n_out      (n_out_q),
        .beat       (beat),
        .wgt_ptr    (wgt_rd_addr),
        .out_idx    (res_idx),
        .issue_last (issue_last),
        .out_last   (out_last)
    );

    // arr_enable trails the read strobe by one cycle so it lines up with read data;
    // the clear pulse only follows acceptance, when no read has yet been issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cmd_ready     <= 1'b1;
            act_rd_en     <= 1'b0;
            arr_enable    <= 1'b0;
            arr_clear_acc <= 1'b0;
            res_valid     <= 1'b0;
            done          <= 1'b0;
            err_unexp     <= 1'b0;
            n_out_q       <= '0;
            n_beats_q     <= '0;
            ret_cnt       <= '0;
            acc           <= '0;
        end else begin
            arr_enable    <= act_rd_en;
            arr_clear_acc <= 1'b0;
            done          <= 1'b0;
            if (arr_valid && (state == IDLE || state == OUTPUT)) err_unexp <= 1'b1;
            case (state)
                IDLE: if (accept) begin
                    n_out_q       <= cmd_n_out;
                    n_beats_q     <= cmd_n_beats;
                    arr_clear_acc <= 1'b1;
                    acc           <= '0;
                    ret_cnt       <= '0;
                    if (cmd_n_out == 8'd0 || cmd_n_beats == 8'd0) begin
                        done <= 1'b1;
                    end else begin
                        state     <= ISSUE;
                        cmd_ready <= 1'b0;
                        act_rd_en <= 1'b1;
                    end
                end
                ISSUE, DRAIN: begin
                    if (arr_valid) begin
                        acc     <= acc + ACC_W'(arr_partial_sum);
                        ret_cnt <= ret_cnt + 8'd1;
                    end
                    if (state == ISSUE && issue_last) begin
                        act_rd_en <= 1'b0;
                        state     <= DRAIN;
                    end
                    if (state == DRAIN && arr_valid && ret_cnt == n_beats_q - 8'd1) begin
                        state     <= OUTPUT;
                        res_valid <= 1'b1;
                        ret_cnt   <= '0;
                    end
                end
                OUTPUT: if (res_ready) begin
                    res_valid <= 1'b0;
                    acc       <= '0;
                    if (out_last) begin
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state     <= ISSUE;
                        act_rd_en <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb_mac_dot_sequencer: randomized self-checking bench with buffer, MAC array and dot-product models
module tb_mac_dot_sequencer;
    localparam int ARR_LAT = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cmd_valid = 1'b0, cmd_ready;
    logic [7:0]         cmd_n_out = '0, cmd_n_beats = '0;
    logic               act_rd_en, wgt_rd_en;
    logic [7:0]         act_rd_addr;
    logic [15:0]        wgt_rd_addr;
    logic [63:0]        act_rd_data = '0, wgt_rd_data = '0;
    logic               arr_enable, arr_clear_acc, arr_valid;
    logic [7:0][7:0]    arr_data, arr_weight;
    logic signed [15:0] arr_partial_sum;
    logic               res_valid, res_ready = 1'b0;
    logic signed [31:0] res_data;
    logic [7:0]         res_idx;
    logic               done, err_unexp;
    logic               inject = 1'b0;

    mac_dot_sequencer #(.ACC_W(32), .BEAT_AW(8), .ARR_LAT(ARR_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_n_out(cmd_n_out), .cmd_n_beats(cmd_n_beats),
        .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
        .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
        .arr_enable(arr_enable), .arr_clear_acc(arr_clear_acc), .arr_data(arr_data), .arr_weight(arr_weight),
        .arr_partial_sum(arr_partial_sum), .arr_valid(arr_valid),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx),
        .done(done), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    logic [63:0] act_mem [0:255];
    logic [63:0] wgt_mem [0:4095];

    always @(posedge clk) begin
        if (act_rd_en) act_rd_data <= act_mem[act_rd_addr];
        if (wgt_rd_en) wgt_rd_data <= wgt_mem[wgt_rd_addr[11:0]];
    end

    function automatic logic signed [15:0] lane_dot(input logic [7:0][7:0] d, input logic [7:0][7:0] w);
        int s = 0;
        for (int l = 0; l < 8; l++) s += int'($signed(d[l])) * int'($signed(w[l]));
        return 16'(s);
    endfunction

    // MAC array: one wrapped 8-lane dot product per enable, returned ARR_LAT cycles later
    logic [ARR_LAT-1:0] vp;
    logic signed [15:0] pp [ARR_LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vp <= '0;
            for (int i = 0; i < ARR_LAT; i++) pp[i] <= '0;
        end else begin
            vp <= {vp[ARR_LAT-2:0], arr_enable};
            pp[0] <= lane_dot(arr_data, arr_weight);
            for (int i = 1; i < ARR_LAT; i++) pp[i] <= pp[i-1];
        end
    end
    assign arr_valid = vp[ARR_LAT-1] | inject;
    assign arr_partial_sum = pp[ARR_LAT-1];

    // reference: neuron o uses activation beats 0..nb-1 and weight beats o*nb..o*nb+nb-1
    function automatic logic signed [31:0] model(input int o, input int nb);
        longint s = 0;
        for (int b = 0; b < nb; b++) begin
            int p = 0;
            for (int l = 0; l < 8; l++)
                p += int'($signed(act_mem[b][8*l +: 8])) * int'($signed(wgt_mem[o*nb+b][8*l +: 8]));
            s += longint'($signed(p[15:0]));
        end
`ifdef MAC_SEQ_RELU_EN
        if (s < 0) s = 0;
`endif
        return 32'(s);
    endfunction

    typedef struct { int a; int w; } rd_t;
    rd_t                rdq [$];
    logic signed [31:0] resq [$];
    logic signed [31:0] got [$];
    int                 checks = 0, errors = 0;
    int                 clear_cnt = 0, done_cnt = 0;
    logic               prev_rd_en = 1'b0, held = 1'b0;
    logic signed [31:0] hold_d;
    logic [7:0]         hold_i, exp_idx;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        rd_t e;
        if (arr_clear_acc || arr_enable || prev_rd_en) begin
            chk("clear_enable_overlap", arr_clear_acc & arr_enable, 0);
            chk("enable_align", arr_enable, prev_rd_en);
        end
        prev_rd_en = act_rd_en;
        if (arr_clear_acc) clear_cnt++;
        if (done) done_cnt++;
        if (act_rd_en || wgt_rd_en) begin
            if (rdq.size() == 0) chk("unexpected_read", act_rd_en | wgt_rd_en, 0);
            else begin
                e = rdq.pop_front();
                chk("rd_en_pair", wgt_rd_en, act_rd_en);
                chk("act_addr", act_rd_addr, e.a);
                chk("wgt_addr", wgt_rd_addr, e.w);
            end
        end
        if (res_valid) begin
            chk("read_during_output", act_rd_en, 0);
            if (held) begin
                chk("hold_data", res_data, hold_d);
                chk("hold_idx", res_idx, hold_i);
            end
            if (res_ready) begin
                if (resq.size() == 0) chk("unexpected_result", res_valid, 0);
                else begin
                    chk("res_data", res_data, resq.pop_front());
                    chk("res_idx", res_idx, exp_idx);
                end
                exp_idx++;
                got.push_back(res_data);
                held = 1'b0;
            end else begin
                held = 1'b1;
                hold_d = res_data;
                hold_i = res_idx;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (rst_n) monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_rd_en"}, {act_rd_en, wgt_rd_en}, 0);
        chk({tag, "_addr"}, {act_rd_addr, wgt_rd_addr}, 0);
        chk({tag, "_arr_ctl"}, {arr_enable, arr_clear_acc}, 0);
        chk({tag, "_res"}, {res_valid, res_data, res_idx}, 0);
        chk({tag, "_done_err"}, {done, err_unexp}, 0);
    endtask

    task automatic fill(input int nb, input int nw, input logic rnd, input logic [63:0] a, input logic [63:0] w);
        for (int i = 0; i < nb; i++) act_mem[i] = rnd ? {$urandom, $urandom} : a;
        for (int i = 0; i < nw; i++) wgt_mem[i] = rnd ? {$urandom, $urandom} : w;
    endtask

    task automatic run_cmd(input int no, input int nb, input int stall, input logic rnd_ready, output int cyc);
        int c0, d0, stall_left;
        rdq.delete();
        resq.delete();
        got.delete();
        exp_idx = '0;
        if (no > 0 && nb > 0)
            for (int o = 0; o < no; o++) begin
                for (int b = 0; b < nb; b++) rdq.push_back('{a: b, w: o*nb + b});
                resq.push_back(model(o, nb));
            end
        c0 = clear_cnt;
        d0 = done_cnt;
        cmd_n_out = 8'(no);
        cmd_n_beats = 8'(nb);
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        cyc = 0;
        stall_left = stall;
        while (done_cnt == d0 && cyc < 3000) begin
            if (res_valid && stall_left > 0) begin
                res_ready = 1'b0;
                stall_left--;
            end else res_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            cyc++;
        end
        res_ready = 1'b0;
        chk("done_timeout", cyc < 3000, 1);
        chk("reads_left", rdq.size(), 0);
        chk("results_left", resq.size(), 0);
        chk("clear_once", clear_cnt - c0, 1);
        chk("done_once", done_cnt - d0, 1);
        chk("ready_after_done", cmd_ready, 1);
        chk("no_err", err_unexp, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, c0;
        localparam logic signed [31:0] T2_EXP =
`ifdef MAC_SEQ_RELU_EN
            32'sd0;
`else
            -32'sd144;
`endif
        repeat (3) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // 1: single neuron, single beat
        fill(1, 1, 1'b0, {8{8'h01}}, {8{8'h02}});
        run_cmd(1, 1, 0, 1'b0, cyc);
        chk("t1_count", got.size(), 1);
        if (got.size() > 0) chk("t1_value", got[0], 32'sd16);

        // 2: two neurons of three beats, negative weights
        fill(3, 6, 1'b0, {8{8'h03}}, {8{8'hFE}});
        run_cmd(2, 3, 0, 1'b0, cyc);
        chk("t2_count", got.size(), 2);
        if (got.size() > 1) begin
            chk("t2_value0", got[0], T2_EXP);
            chk("t2_value1", got[1], T2_EXP);
        end

        // 3: same with a 10-cycle stall on the first result
        run_cmd(2, 3, 10, 1'b0, cyc);
        chk("t3_count", got.size(), 2);

        // 4: empty commands complete the cycle after acceptance
        run_cmd(4, 0, 0, 1'b0, cyc);
        chk("t4_done_latency", cyc, 1);
        run_cmd(0, 5, 0, 1'b0, cyc);
        chk("t4b_done_latency", cyc, 1);

        // randomized commands, data and backpressure
        for (int t = 0; t < 12; t++) begin
            int no = $urandom_range(1, 4), nb = $urandom_range(1, 12);
            fill(nb, no * nb, 1'b1, '0, '0);
            run_cmd(no, nb, $urandom_range(0, 3), 1'b1, cyc);
        end

        // 5: busy command ignored, then reset mid-ISSUE
        fill(8, 16, 1'b1, '0, '0);
        rdq.delete();
        for (int b = 0; b < 8; b++) rdq.push_back('{a: b, w: b});
        c0 = clear_cnt;
        cmd_n_out = 8'd2;
        cmd_n_beats = 8'd8;
        cmd_valid = 1'b1;
        step();
        cmd_n_out = 8'd1;
        cmd_n_beats = 8'd1;
        repeat (3) step();
        chk("busy_not_ready", cmd_ready, 0);
        chk("busy_rd_en", act_rd_en, 1);
        chk("busy_single_clear", clear_cnt - c0, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        cmd_valid = 1'b0;
        rdq.delete();
        resq.delete();
        prev_rd_en = 1'b0;
        held = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        c0 = clear_cnt;
        repeat (8) step();
        chk("post_reset_idle", {cmd_ready, act_rd_en, res_valid, err_unexp}, 4'b1000);
        chk("post_reset_no_clear", clear_cnt - c0, 0);
        inject = 1'b1;
        step();
        inject = 1'b0;
        step();
        chk("err_set", err_unexp, 1);
        repeat (3) step();
        chk("err_sticky", err_unexp, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
